// File: rtl/computer_v2.sv
// rtl/computer_v2.sv - single-cycle accumulator-style computer with ALU, flags, jumps and halt
// Executes one instruction per enabled cycle from an external combinational program memory.
module computer_v2 #(
  parameter int DW = 8,
  parameter int AW = 6,
  localparam int IW = DW + 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [IW-1:0] instr,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] alu_out,
  output logic [DW-1:0] reg_a,
  output logic [DW-1:0] reg_b,
  output logic [3:0]    flags,
  output logic          halted,
  output logic [15:0]   instret
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  localparam logic [2:0] JC_ALU  = 3'b000;
  localparam logic [2:0] JC_JMP  = 3'b001;
  localparam logic [2:0] JC_JEQ  = 3'b010;
  localparam logic [2:0] JC_JNE  = 3'b011;
  localparam logic [2:0] JC_JGT  = 3'b100;
  localparam logic [2:0] JC_JLT  = 3'b101;
  localparam logic [2:0] JC_JCS  = 3'b110;
  localparam logic [2:0] JC_HALT = 3'b111;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] reg_a_q, reg_a_d;
  logic [DW-1:0] reg_b_q, reg_b_d;
  logic [3:0]    flags_q, flags_d;
  logic [15:0]   instret_q, instret_d;

  logic [DW-1:0] lit;
  logic [2:0]    op;
  logic          ld_a, ld_b, sel_b;
  logic [2:0]    jc;

  assign lit   = instr[DW-1:0];
  assign op    = instr[DW+2:DW];
  assign ld_a  = instr[DW+3];
  assign ld_b  = instr[DW+4];
  assign sel_b = instr[DW+5];
  assign jc    = instr[DW+8:DW+6];

  logic [DW-1:0] opa, opb, res;
  logic [DW:0]   sum_w, diff_w;
  logic          c_out, v_out;
  logic [3:0]    alu_flags;

  always_comb begin
    opa    = reg_a_q;
    opb    = sel_b ? lit : reg_b_q;
    sum_w  = {1'b0, opa} + {1'b0, opb};
    diff_w = {1'b0, opa} - {1'b0, opb};
    res    = '0;
    c_out  = 1'b0;
    v_out  = 1'b0;
    case (op)
      OP_ADD: begin
        res   = sum_w[DW-1:0];
        c_out = sum_w[DW];
        v_out = (opa[DW-1] == opb[DW-1]) && (res[DW-1] != opa[DW-1]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the unsigned borrow (a < b).
        res   = diff_w[DW-1:0];
        c_out = diff_w[DW];
        v_out = (opa[DW-1] != opb[DW-1]) && (res[DW-1] != opa[DW-1]);
      end
      OP_AND: res = opa & opb;
      OP_OR:  res = opa | opb;
      OP_XOR: res = opa ^ opb;
      OP_NOT: res = ~opa;
      OP_SHL: begin
        res   = {opa[DW-2:0], 1'b0};
        c_out = opa[DW-1];
      end
      OP_SHR: begin
        res   = {1'b0, opa[DW-1:1]};
        c_out = opa[0];
      end
      default: res = '0;
    endcase
    alu_flags = {(res == '0), res[DW-1], c_out, v_out};
  end

  logic taken;

  always_comb begin
    taken = 1'b0;
    case (jc)
      JC_JMP:  taken = 1'b1;
      JC_JEQ:  taken = flags_q[3];
      JC_JNE:  taken = !flags_q[3];
      JC_JGT:  taken = !flags_q[3] && !flags_q[2];
      JC_JLT:  taken = flags_q[2];
      JC_JCS:  taken = flags_q[1];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    reg_a_d   = reg_a_q;
    reg_b_d   = reg_b_q;
    flags_d   = flags_q;
    instret_d = instret_q;
    if (en && state_q == ST_RUN) begin
      if (jc == JC_HALT) begin
        state_d = ST_HALT;
      end else begin
        instret_d = (instret_q == 16'hFFFF) ? instret_q : instret_q + 16'd1;
        if (jc == JC_ALU) begin
          if (ld_a) reg_a_d = res;
          if (ld_b) reg_b_d = res;
          flags_d = alu_flags;
          pc_d    = pc_q + AW'(1);
        end else begin
          pc_d = taken ? lit[AW-1:0] : pc_q + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      pc_q      <= '0;
      reg_a_q   <= '0;
      reg_b_q   <= '0;
      flags_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      reg_a_q   <= reg_a_d;
      reg_b_q   <= reg_b_d;
      flags_q   <= flags_d;
      instret_q <= instret_d;
    end
  end

  assign pc      = pc_q;
  assign alu_out = res;
  assign reg_a   = reg_a_q;
  assign reg_b   = reg_b_q;
  assign flags   = flags_q;
  assign halted  = (state_q == ST_HALT);
  assign instret = instret_q;

endmodule

// File: tb/tb_computer_v2.sv
// tb/tb_computer_v2.sv - directed self-checking bench for computer_v2
module tb_computer_v2;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [16:0] instr;
  logic [5:0]  pc;
  logic [7:0]  alu_out;
  logic [7:0]  reg_a;
  logic [7:0]  reg_b;
  logic [3:0]  flags;
  logic        halted;
  logic [15:0] instret;

  int errors = 0;
  int checks = 0;

  computer_v2 #(.DW(8), .AW(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .instr   (instr),
    .pc      (pc),
    .alu_out (alu_out),
    .reg_a   (reg_a),
    .reg_b   (reg_b),
    .flags   (flags),
    .halted  (halted),
    .instret (instret)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] enc(input logic [2:0] jc, input logic sel, input logic lb,
                                      input logic la, input logic [2:0] op, input logic [7:0] lit);
    return {jc, sel, lb, la, op, lit};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [16:0] v);
    @(negedge clk);
    instr = v;
    @(posedge clk);
    #1;
  endtask

  task automatic state_chk(input string tag, input logic [5:0] e_pc, input logic [7:0] e_a,
                           input logic [7:0] e_b, input logic [3:0] e_f, input logic e_h,
                           input logic [15:0] e_ir);
    check({tag, ".pc"}, 32'(pc), 32'(e_pc));
    check({tag, ".reg_a"}, 32'(reg_a), 32'(e_a));
    check({tag, ".reg_b"}, 32'(reg_b), 32'(e_b));
    check({tag, ".flags"}, 32'(flags), 32'(e_f));
    check({tag, ".halted"}, 32'(halted), 32'(e_h));
    check({tag, ".instret"}, 32'(instret), 32'(e_ir));
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    instr = '0;
    step(enc(3'b000, 1, 0, 1, 3'b000, 8'h05));
    state_chk("reset", 6'd0, 8'h00, 8'h00, 4'b0000, 1'b0, 16'd0);
    reset = 1'b0;
    en    = 1'b1;

    step(enc(3'b000, 1, 0, 1, 3'b000, 8'h05));
    state_chk("add_first", 6'd1, 8'h05, 8'h00, 4'b0000, 1'b0, 16'd1);

    step(enc(3'b000, 1, 0, 1, 3'b000, 8'h7A));
    check("set_7f", 32'(reg_a), 32'h7F);
    step(enc(3'b000, 1, 0, 1, 3'b000, 8'h01));
    state_chk("add_ovf", 6'd3, 8'h80, 8'h00, 4'b0101, 1'b0, 16'd3);

    @(negedge clk);
    instr = enc(3'b000, 1, 0, 0, 3'b001, 8'h81);
    #1;
    check("sub_alu_out", 32'(alu_out), 32'hFF);
    @(posedge clk);
    #1;
    state_chk("sub_borrow", 6'd4, 8'h80, 8'h00, 4'b0110, 1'b0, 16'd4);

    step(enc(3'b000, 1, 0, 0, 3'b000, 8'h80));
    check("add_carry.flags", 32'(flags), 32'b1011);

    step(enc(3'b000, 1, 1, 1, 3'b010, 8'h00));
    check("and_zero.flags", 32'(flags), 32'b1000);
    step(enc(3'b000, 1, 1, 1, 3'b000, 8'h33));
    step(enc(3'b000, 0, 0, 0, 3'b001, 8'h00));
    state_chk("sub_eq", 6'd8, 8'h33, 8'h33, 4'b1000, 1'b0, 16'd8);
    step(enc(3'b010, 1, 1, 1, 3'b000, 8'h20));
    state_chk("jeq_taken", 6'h20, 8'h33, 8'h33, 4'b1000, 1'b0, 16'd9);

    step(enc(3'b000, 1, 1, 0, 3'b000, 8'h01));
    step(enc(3'b000, 0, 0, 0, 3'b001, 8'h00));
    step(enc(3'b010, 0, 0, 0, 3'b000, 8'h20));
    state_chk("jeq_not", 6'h23, 8'h33, 8'h34, 4'b0110, 1'b0, 16'd12);

    step(enc(3'b110, 0, 0, 0, 3'b000, 8'h10));
    check("jcs_taken", 32'(pc), 32'h10);
    step(enc(3'b101, 0, 0, 0, 3'b000, 8'h3E));
    check("jlt_taken", 32'(pc), 32'h3E);
    step(enc(3'b100, 0, 0, 0, 3'b000, 8'h05));
    check("jgt_not", 32'(pc), 32'h3F);

    step(enc(3'b000, 1, 0, 0, 3'b100, 8'h0F));
    state_chk("pc_wrap", 6'd0, 8'h33, 8'h34, 4'b0000, 1'b0, 16'd16);
    step(enc(3'b001, 0, 0, 0, 3'b000, 8'hFF));
    check("jmp_trunc", 32'(pc), 32'h3F);

    step(enc(3'b000, 0, 0, 0, 3'b111, 8'h00));
    check("shr.flags", 32'(flags), 32'b0010);
    check("shr.pc", 32'(pc), 32'd0);
    @(negedge clk);
    instr = enc(3'b000, 0, 0, 0, 3'b101, 8'h00);
    #1;
    check("not_alu_out", 32'(alu_out), 32'hCC);
    @(posedge clk);
    #1;
    state_chk("not", 6'd1, 8'h33, 8'h34, 4'b0100, 1'b0, 16'd19);

    en = 1'b0;
    for (int i = 0; i < 3; i++) step(enc(3'b000, 1, 0, 1, 3'b000, 8'h01));
    check("stall_alu_out", 32'(alu_out), 32'h34);
    state_chk("stall", 6'd1, 8'h33, 8'h34, 4'b0100, 1'b0, 16'd19);
    en = 1'b1;
    step(enc(3'b000, 1, 0, 1, 3'b000, 8'h01));
    state_chk("resume", 6'd2, 8'h34, 8'h34, 4'b0000, 1'b0, 16'd20);

    step(enc(3'b001, 0, 0, 0, 3'b000, 8'h04));
    step(enc(3'b111, 1, 1, 1, 3'b000, 8'h10));
    state_chk("halt", 6'd4, 8'h34, 8'h34, 4'b0000, 1'b1, 16'd21);
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) step(enc(3'b000, 1, 1, 1, 3'b000, 8'(i + 1)));
      else            step(enc(3'b001, 0, 0, 0, 3'b000, 8'h11));
    end
    state_chk("halt_hold", 6'd4, 8'h34, 8'h34, 4'b0000, 1'b1, 16'd21);

    en    = 1'b0;
    reset = 1'b1;
    step(enc(3'b000, 1, 0, 1, 3'b000, 8'h09));
    state_chk("reset_en0", 6'd0, 8'h00, 8'h00, 4'b0000, 1'b0, 16'd0);
    reset = 1'b0;
    en    = 1'b1;
    step(enc(3'b000, 1, 0, 1, 3'b000, 8'h09));
    state_chk("restart", 6'd1, 8'h09, 8'h00, 4'b0000, 1'b0, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
